// File: rtl/route_compute_stage.sv
// route_compute_stage: 2-entry input FIFO, XY route compute on the FIFO head, registered output stage.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_pkt upstream handshake;
//   out_valid/out_ready/out_pkt/out_req downstream handshake with one-hot {L,S,N,W,E} request;
//   cnt_e/w/n/s/l per-direction forwarded-packet counters.
// Config: define ROUTE_CNT_EN to build the counters; otherwise they read 0.
module hdr_fields (
  input  logic [63:0] pkt_i,
  output logic        vc_o,
  output logic        dx_o,
  output logic        dy_o,
  output logic [4:0]  rsv_o,
  output logic [3:0]  hx_o,
  output logic [3:0]  hy_o,
  output logic [7:0]  srcx_o,
  output logic [7:0]  srcy_o,
  output logic [31:0] payload_o
);
  assign {vc_o, dx_o, dy_o, rsv_o, hx_o, hy_o, srcx_o, srcy_o, payload_o} = pkt_i;
endmodule

module route_compute_stage #(
  parameter int PKT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic [4:0]       out_req,
  output logic [CNT_W-1:0] cnt_e,
  output logic [CNT_W-1:0] cnt_w,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_s,
  output logic [CNT_W-1:0] cnt_l
);
  logic [PKT_W-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             out_valid_q;
  logic [PKT_W-1:0] out_pkt_q, route_pkt;
  logic [4:0]       out_req_q, route_req;
  logic             push, pop;
  logic             vc, dx, dy;
  logic [4:0]       rsv;
  logic [3:0]       hx, hy, hx_d, hy_d;
  logic [7:0]       srcx, srcy;
  logic [31:0]      payload;

  hdr_fields u_hdr (
    .pkt_i(mem_q[rd_ptr_q]), .vc_o(vc), .dx_o(dx), .dy_o(dy), .rsv_o(rsv),
    .hx_o(hx), .hy_o(hy), .srcx_o(srcx), .srcy_o(srcy), .payload_o(payload)
  );

  assign in_ready = cnt_q != 2'd2;
  assign push     = in_valid & in_ready;
  assign pop      = (cnt_q != 2'd0) & (~out_valid_q | out_ready);
  assign cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};

  // X is exhausted before Y is touched; a zero hop field is never decremented.
  always_comb begin
    hx_d      = hx != 4'd0 ? hx - 4'd1 : hx;
    hy_d      = hx == 4'd0 && hy != 4'd0 ? hy - 4'd1 : hy;
    route_req = hx != 4'd0 ? (dx ? 5'b00010 : 5'b00001) :
                hy != 4'd0 ? (dy ? 5'b01000 : 5'b00100) : 5'b10000;
    route_pkt = {vc, dx, dy, rsv, hx_d, hy_d, srcx, srcy, payload};
  end

  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= in_pkt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      out_req_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      if (pop) begin
        out_valid_q <= 1'b1;
        out_pkt_q   <= route_pkt;
        out_req_q   <= route_req;
      end else if (out_ready) out_valid_q <= 1'b0;
    end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign out_req   = out_req_q;

`ifdef ROUTE_CNT_EN
  logic [CNT_W-1:0] dir_cnt_q [5];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 5; i++) dir_cnt_q[i] <= '0;
    else for (int i = 0; i < 5; i++)
      if (out_valid_q & out_ready & out_req_q[i]) dir_cnt_q[i] <= dir_cnt_q[i] + CNT_W'(1);
  assign cnt_e = dir_cnt_q[0];
  assign cnt_w = dir_cnt_q[1];
  assign cnt_n = dir_cnt_q[2];
  assign cnt_s = dir_cnt_q[3];
  assign cnt_l = dir_cnt_q[4];
`else
  assign cnt_e = '0;
  assign cnt_w = '0;
  assign cnt_n = '0;
  assign cnt_s = '0;
  assign cnt_l = '0;
`endif
endmodule
